// File: rtl/counter_ctrl_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : counter_ctrl_unit                                            |
// | Description : Run/stop/clear/mode sequencer for the 0..9999 FND counter.   |
// |               Converts debounced button levels into a gated count tick,    |
// |               a one-cycle clear pulse and an up/down mode bit, and owns    |
// |               the tick prescaler.                                          |
// | Ports       : clk          system clock, rising edge                       |
// |               reset        asynchronous, active-low reset                  |
// |               i_btn_run    debounced run/stop level (clk-synchronous)      |
// |               i_btn_clear  debounced clear level (clk-synchronous)         |
// |               i_btn_mode   debounced up/down mode level (clk-synchronous)  |
// |               i_count      current counter value from the datapath         |
// |               o_tick       one-cycle count enable                          |
// |               o_clear      one-cycle synchronous clear                     |
// |               o_mode       0 = count up, 1 = count down                    |
// |               o_run        high while running (status LED)                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module counter_ctrl_unit #(
   parameter int TICK_DIV = 10_000_000,
   parameter int CNT_W    = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_btn_run,
   input  logic             i_btn_clear,
   input  logic             i_btn_mode,
   input  logic [CNT_W-1:0] i_count,
   output logic             o_tick,
   output logic             o_clear,
   output logic             o_mode,
   output logic             o_run
);

   localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(TICK_DIV - 1);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_run   = 2'd1;
   localparam logic [1:0] c_st_stop  = 2'd2;
   localparam logic [1:0] c_st_clear = 2'd3;

   logic [1:0]         r_state;
   logic [1:0]         w_state_next;
   logic [PRESC_W-1:0] r_presc;
   logic [PRESC_W-1:0] w_presc_next;

   logic r_run_q;
   logic r_clear_q;
   logic r_mode_q;
   // Low until the first clock after reset release, so a button already held
   // when reset lifts is absorbed into the delay registers without an event.
   logic r_primed;

   logic w_ev_run;
   logic w_ev_clear;
   logic w_ev_mode;
   logic w_wrap;
   logic w_down_limit;
   logic w_tick_next;
   logic w_clear_next;
   logic w_run_next;
   logic w_mode_next;

   // ---------------------------------------------------------------- edges
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_run_q   <= 1'b0;
         r_clear_q <= 1'b0;
         r_mode_q  <= 1'b0;
         r_primed  <= 1'b0;
      end else begin
         r_run_q   <= i_btn_run;
         r_clear_q <= i_btn_clear;
         r_mode_q  <= i_btn_mode;
         r_primed  <= 1'b1;
      end
   end

   assign w_ev_run   = r_primed & i_btn_run   & ~r_run_q;
   assign w_ev_clear = r_primed & i_btn_clear & ~r_clear_q;
   assign w_ev_mode  = r_primed & i_btn_mode  & ~r_mode_q;

   // Prescaler wrap point and the down-count floor that stops the run there.
   assign w_wrap       = (r_state == c_st_run) && (r_presc == c_presc_max);
   assign w_down_limit = w_wrap && o_mode && (i_count == '0);

   // --------------------------------------------------------- state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------ next state
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (w_ev_clear)    w_state_next = c_st_clear;
            else if (w_ev_run) w_state_next = c_st_run;
         end
         c_st_run: begin
            if (w_ev_clear)        w_state_next = c_st_clear;
            else if (w_ev_run)     w_state_next = c_st_stop;
            else if (w_down_limit) w_state_next = c_st_stop;
         end
         c_st_stop: begin
            if (w_ev_clear)    w_state_next = c_st_clear;
            else if (w_ev_run) w_state_next = c_st_run;
         end
         default: begin
            // Clear lasts a single cycle and ignores every button.
            w_state_next = c_st_idle;
         end
      endcase
   end

   // ---------------------------------------------------------- output logic
   always_comb begin
      w_run_next   = (w_state_next == c_st_run);
      w_clear_next = (w_state_next == c_st_clear);
      // A wrap only produces a tick if the unit stays in RUN; this covers the
      // down-count floor and keeps a tick from colliding with a clear.
      w_tick_next  = w_wrap && (w_state_next == c_st_run);

      w_mode_next = o_mode;
      if (w_ev_mode && ((r_state == c_st_idle) || (r_state == c_st_stop))) begin
         w_mode_next = ~o_mode;
      end

      // Phase is not kept across a stop: anything but continued RUN zeroes it.
      w_presc_next = '0;
      if ((r_state == c_st_run) && (w_state_next == c_st_run)) begin
         w_presc_next = (r_presc == c_presc_max) ? '0 : r_presc + PRESC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
         o_tick  <= 1'b0;
         o_clear <= 1'b0;
         o_mode  <= 1'b0;
         o_run   <= 1'b0;
      end else begin
         r_presc <= w_presc_next;
         o_tick  <= w_tick_next;
         o_clear <= w_clear_next;
         o_mode  <= w_mode_next;
         o_run   <= w_run_next;
      end
   end

endmodule
`default_nettype wire
